serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 78 +++++++
 tb/tb_serial_subtractor.sv | 132 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor computing a - b - bin, LSB first, one bit per cycle.
//   clk   : clock, all state changes on rising edge
//   rst   : synchronous active-high reset
//   start : begin a subtraction (honoured in IDLE or DONE only)
//   a, b  : minuend / subtrahend, latched on the accepted start cycle
//   bin   : borrow-in, latched on the accepted start cycle
//   busy  : high during the WIDTH shift cycles
//   done  : one-cycle pulse when diff/bout take the new result
//   diff  : a - b - bin modulo 2^WIDTH, held until the next result
//   bout  : borrow-out, 1 when a < b + bin
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, sh;
    logic [CW-1:0]    cnt;
    logic             br, accept, last, ai, bi, d, br_nx;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        accept   = start && (state == IDLE || state == DONE);
        last     = cnt == CW'(WIDTH - 1);
        ai       = a_q[cnt];
        bi       = b_q[cnt];
        d        = ai ^ bi ^ br;
        br_nx    = (~ai & bi) | (~(ai ^ bi) & br);
        state_nx = (state == SHIFT) ? (last ? DONE : SHIFT) : (accept ? SHIFT : IDLE);
        busy     = state == SHIFT;
        done     = state == DONE;
    end

    // The shift register fills from the MSB end; diff is a separate output
    // register so the previous result stays visible while a new one is built.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            sh   <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            a_q <= a;
            b_q <= b;
            br  <= bin;
            cnt <= '0;
            sh  <= '0;
        end else if (state == SHIFT) begin
            sh  <= {d, sh[WIDTH-1:1]};
            br  <= br_nx;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                diff <= {d, sh[WIDTH-1:1]};
                bout <= br_nx;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst, start, bin, busy, done, bout;
    logic [3:0] a, b, diff;
    int         checks = 0;
    int         errors = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full transaction: start accepted at the next edge, four busy cycles, then done.
    task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                          input logic tbin, input logic [3:0] ed, input logic eb);
        logic [3:0] pd;
        logic       pb;
        pd = diff;
        pb = bout;
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check({tag, " busy"}, busy, 1);
            check({tag, " nodone"}, done, 0);
            check({tag, " hold"}, {pb, pd}, {bout, diff});
            tick();
        end
        check({tag, " done"}, done, 1);
        check({tag, " notbusy"}, busy, 0);
        check({tag, " diff"}, diff, ed);
        check({tag, " bout"}, bout, eb);
        tick();
        check({tag, " idle"}, {busy, done}, 0);
        check({tag, " held"}, {bout, diff}, {eb, ed});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick();
        tick();
        check("rst state", {busy, done, bout, diff}, 0);
        start = 1'b1;
        tick();
        check("rst start ignored", {busy, done}, 0);
        rst = 1'b0; start = 1'b0;
        tick();

        run_op("v1", 4'b0101, 4'b1111, 1'b0, 4'b0110, 1'b1);
        run_op("v2", 4'b1000, 4'b0011, 1'b1, 4'b0100, 1'b0);
        run_op("v3", 4'b0011, 4'b0100, 1'b0, 4'b1111, 1'b1);
        run_op("v4", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1);
        run_op("v5", 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0);

        // back-to-back: start stays high, new operands presented in DONE
        a = 4'b0101; b = 4'b1111; bin = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("b2b busy1", busy, 1);
            tick();
        end
        check("b2b done1", done, 1);
        check("b2b diff1", {bout, diff}, 5'b1_0110);
        a = 4'b0010; b = 4'b0001; bin = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b busy2", busy, 1);
            check("b2b held1", {bout, diff}, 5'b1_0110);
            tick();
        end
        check("b2b done2", done, 1);
        check("b2b diff2", {bout, diff}, 5'b0_0001);
        tick();

        // inputs and start toggled mid-operation must be ignored
        a = 4'b1000; b = 4'b0011; bin = 1'b1; start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
            start = (i < 3) ? ~start : 1'b0;
            check("tog busy", busy, 1);
            tick();
        end
        check("tog done", done, 1);
        check("tog diff", {bout, diff}, 5'b0_0100);
        start = 1'b0;
        tick();

        // reset in the second SHIFT cycle aborts with no done pulse
        a = 4'b0101; b = 4'b1111; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort state", {busy, done, bout, diff}, 0);
        for (int i = 0; i < 6; i++) begin
            check("abort nodone", done, 0);
            tick();
        end
        run_op("post", 4'b0011, 4'b0100, 1'b0, 4'b1111, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        if (busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap: got busy=%b done=%b expected not both", busy, done);
        end
    end
endmodule
